// File: rtl/acq_pkg.sv
// Shared types and default widths for the code-phase acquisition sweep.
package acq_pkg;

  localparam int SHIFT_WIDTH = 15;
  localparam int ACC_WIDTH   = 19;
  localparam int SUM_WIDTH   = ACC_WIDTH + 2;
  localparam int PRN_WIDTH   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_SETTLE,
    ST_INTEG,
    ST_EVAL,
    ST_DONE
  } acq_state_e;

endpackage

// File: rtl/acq_mag.sv
// Absolute value of a two's-complement accumulator.
// The most negative input saturates to the largest positive magnitude.
module acq_mag #(
  parameter int ACC_WIDTH = acq_pkg::ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [ACC_WIDTH-2:0] mag
);

  always_comb begin
    if (!acc[ACC_WIDTH-1]) begin
      mag = acc[ACC_WIDTH-2:0];
    end else if (acc[ACC_WIDTH-2:0] == '0) begin
      mag = '1;
    end else begin
      // Low bits of -acc; the sign bit is known to clear for this range.
      mag = ~acc[ACC_WIDTH-2:0] + (ACC_WIDTH-1)'(1);
    end
  end

endmodule

// File: rtl/acq_sweep_ctrl.sv
// Code-phase sweep sequencer: seek each candidate shift, drop the settle dump,
// sum DWELL dump magnitudes, and track the best shift against a threshold.
module acq_sweep_ctrl #(
  parameter int SHIFT_WIDTH  = acq_pkg::SHIFT_WIDTH,
  parameter int ACC_WIDTH    = acq_pkg::ACC_WIDTH,
  parameter int SHIFT_MAX    = 16799,
  parameter int SHIFT_STEP   = 8,
  parameter int DWELL        = 2,
  parameter int SEEK_TIMEOUT = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [acq_pkg::PRN_WIDTH-1:0]   prn_in,
  input  logic [ACC_WIDTH+1:0]            threshold,
  input  logic                            seek_done,
  input  logic                            dump,
  input  logic [ACC_WIDTH-1:0]            accumulator,
  output logic [acq_pkg::PRN_WIDTH-1:0]   prn,
  output logic                            seek_en,
  output logic [SHIFT_WIDTH-1:0]          seek_target,
  output logic                            busy,
  output logic                            done,
  output logic                            found,
  output logic                            timeout,
  output logic [SHIFT_WIDTH-1:0]          best_shift,
  output logic [ACC_WIDTH+1:0]            best_mag
);

  import acq_pkg::*;

  localparam int SUM_W = ACC_WIDTH + 2;
  localparam int TMO_W = $clog2(SEEK_TIMEOUT + 1);
  localparam int CNT_W = 3;

  acq_state_e              state_q, state_d;
  logic [PRN_WIDTH-1:0]    prn_q, prn_d;
  logic [SUM_W-1:0]        thr_q, thr_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [SUM_W-1:0]        best_mag_q, best_mag_d;
  logic [SHIFT_WIDTH-1:0]  cur_shift_q, cur_shift_d;
  logic [SHIFT_WIDTH-1:0]  best_shift_q, best_shift_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    found_q, found_d;
  logic                    timeout_q, timeout_d;
  logic                    done_q, done_d;
  logic [ACC_WIDTH-2:0]    acc_mag;
  logic [SHIFT_WIDTH:0]    next_shift;

  acq_mag #(.ACC_WIDTH(ACC_WIDTH)) u_mag (
    .acc (accumulator),
    .mag (acc_mag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prn_q        <= '0;
      thr_q        <= '0;
      sum_q        <= '0;
      best_mag_q   <= '0;
      cur_shift_q  <= '0;
      best_shift_q <= '0;
      tmo_q        <= '0;
      cnt_q        <= '0;
      found_q      <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prn_q        <= prn_d;
      thr_q        <= thr_d;
      sum_q        <= sum_d;
      best_mag_q   <= best_mag_d;
      cur_shift_q  <= cur_shift_d;
      best_shift_q <= best_shift_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      found_q      <= found_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prn_d        = prn_q;
    thr_d        = thr_q;
    sum_d        = sum_q;
    best_mag_d   = best_mag_q;
    cur_shift_d  = cur_shift_q;
    best_shift_d = best_shift_q;
    cnt_d        = cnt_q;
    found_d      = found_q;
    timeout_d    = timeout_q;
    tmo_d        = '0;
    // One extra bit so the step past SHIFT_MAX cannot wrap back to a legal shift.
    next_shift   = {1'b0, cur_shift_q} + (SHIFT_WIDTH+1)'(SHIFT_STEP);

    // Abort freezes every result register; only the state returns to idle.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d      = ST_SEEK;
            prn_d        = prn_in;
            thr_d        = threshold;
            cur_shift_d  = '0;
            best_shift_d = '0;
            best_mag_d   = '0;
            found_d      = 1'b0;
            timeout_d    = 1'b0;
          end
        end
        ST_SEEK: begin
          if (seek_done) begin
            state_d = ST_SETTLE;
          end else if (tmo_q == TMO_W'(SEEK_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_SETTLE: begin
          if (dump) begin
            state_d = ST_INTEG;
            sum_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_INTEG: begin
          if (dump) begin
            sum_d = sum_q + SUM_W'(acc_mag);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DWELL - 1)) begin
              state_d = ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          if (sum_q > best_mag_q) begin
            best_mag_d   = sum_q;
            best_shift_d = cur_shift_q;
          end
          if (sum_q >= thr_q) begin
            found_d = 1'b1;
            state_d = ST_DONE;
          end else if (next_shift > (SHIFT_WIDTH+1)'(SHIFT_MAX)) begin
            state_d = ST_DONE;
          end else begin
            cur_shift_d = next_shift[SHIFT_WIDTH-1:0];
            state_d     = ST_SEEK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_comb begin
    seek_en     = (state_q == ST_SEEK);
    busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    seek_target = cur_shift_q;
    prn         = prn_q;
    done        = done_q;
    found       = found_q;
    timeout     = timeout_q;
    best_shift  = best_shift_q;
    best_mag    = best_mag_q;
  end

endmodule

// File: tb/tb_acq_sweep_ctrl.sv
// Directed bench for acq_sweep_ctrl with a behavioural subchannel responder
// and a scoreboard of expected sweep outcomes popped on each done pulse.
module tb_acq_sweep_ctrl;

  typedef struct {
    logic        found;
    logic        tmo;
    logic [14:0] shift;
    logic [20:0] mag;
    int          ncand;
    logic [4:0]  prn;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic        clk = 1'b0;
  logic        reset, start, start4, abort, seek_done, dump;
  logic [4:0]  prn_in;
  logic [20:0] threshold;
  logic [18:0] accumulator;

  logic [4:0]  prn_a, prn_b;
  logic        seek_en_a, seek_en_b, busy_a, busy_b, done_a, done_b;
  logic        found_a, found_b, timeout_a, timeout_b;
  logic [14:0] seek_target_a, seek_target_b, best_shift_a, best_shift_b;
  logic [20:0] best_mag_a, best_mag_b;

  localparam logic [18:0] BIG = 19'd200000;

  always #5 clk = ~clk;

  acq_sweep_ctrl #(
    .SHIFT_MAX(31), .SHIFT_STEP(8), .DWELL(2), .SEEK_TIMEOUT(100)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .prn_in(prn_in), .threshold(threshold), .seek_done(seek_done),
    .dump(dump), .accumulator(accumulator), .prn(prn_a),
    .seek_en(seek_en_a), .seek_target(seek_target_a), .busy(busy_a),
    .done(done_a), .found(found_a), .timeout(timeout_a),
    .best_shift(best_shift_a), .best_mag(best_mag_a)
  );

  acq_sweep_ctrl #(
    .SHIFT_MAX(31), .SHIFT_STEP(8), .DWELL(4), .SEEK_TIMEOUT(100)
  ) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(abort),
    .prn_in(prn_in), .threshold(threshold), .seek_done(seek_done),
    .dump(dump), .accumulator(accumulator), .prn(prn_b),
    .seek_en(seek_en_b), .seek_target(seek_target_b), .busy(busy_b),
    .done(done_b), .found(found_b), .timeout(timeout_b),
    .best_shift(best_shift_b), .best_mag(best_mag_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic f, input logic t, input logic [14:0] s,
                                  input logic [20:0] m, input int n, input logic [4:0] p);
    exp_t e;
    e.found = f; e.tmo = t; e.shift = s; e.mag = m; e.ncand = n; e.prn = p;
    return e;
  endfunction

  // Dump value seen by the subchannel for a given shift and dump index.
  function automatic logic [18:0] acc_val(input int mode, input logic [14:0] sh, input int k);
    int v;
    case (mode)
      1:       v = (sh == 15'd16) ? 300 : 10;
      2:       v = (sh == 15'd0 || sh == 15'd8) ? 7 : 3;
      default: v = 10;
    endcase
    if (mode == 3) return 19'h40000;
    if (mode == 1 && sh == 15'd16) return 19'(-v);
    return (k % 2 == 1) ? 19'(-v) : 19'(v);
  endfunction

  task automatic check_zero_a(input string pfx);
    chk({pfx, "_prn"}, prn_a, 0);
    chk({pfx, "_seek_en"}, seek_en_a, 0);
    chk({pfx, "_seek_target"}, seek_target_a, 0);
    chk({pfx, "_busy"}, busy_a, 0);
    chk({pfx, "_done"}, done_a, 0);
    chk({pfx, "_found"}, found_a, 0);
    chk({pfx, "_timeout"}, timeout_a, 0);
    chk({pfx, "_best_shift"}, best_shift_a, 0);
    chk({pfx, "_best_mag"}, best_mag_a, 0);
  endtask

  task automatic drive_start(input int sel, input logic [4:0] p, input logic [20:0] thr,
                             input bit push, input exp_t e);
    @(negedge clk);
    prn_in = p;
    threshold = thr;
    if (sel == 0) start = 1'b1; else start4 = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    start4 = 1'b0;
    chk("start_busy", sel ? busy_b : busy_a, 1);
    chk("start_seek_en", sel ? seek_en_b : seek_en_a, 1);
    chk("start_prn", sel ? prn_b : prn_a, p);
  endtask

  // action: 0 = run to done, 1 = abort+start mid-INTEG of shift 8, 2 = reset in SEEK of shift 16
  task automatic run_sweep(input int sel, input int mode, input bit seek_resp,
                           input bit big_settle, input bit poke, input int action);
    int cyc = 0, seek_cnt = 0, first_seek = -1, last_dump = -1;
    int nsought = 0, ndump = 0, integ_dumps = 0, act_at = -1;
    bit settle_flag = 0, got = 0, fin = 0;
    logic [14:0] cur_sh = '0;
    logic [4:0] prn0;
    logic [14:0] sought[$];
    logic se, dn, bz;
    logic [14:0] st;
    exp_t e;
    prn0 = prn_in;
    while (!fin && cyc < 3000) begin
      se = sel ? seek_en_b : seek_en_a;
      dn = sel ? done_b : done_a;
      bz = sel ? busy_b : busy_a;
      st = sel ? seek_target_b : seek_target_a;
      if (act_at >= 0) begin
        if (cyc == act_at + 1) begin
          if (action == 1) begin
            chk("abort_busy", busy_a, 0);
            chk("abort_seek_en", seek_en_a, 0);
            chk("abort_done", done_a, 0);
            chk("abort_best_mag_hold", best_mag_a, 20);
            chk("abort_best_shift_hold", best_shift_a, 0);
            chk("abort_found_hold", found_a, 0);
          end else begin
            check_zero_a("reset_mid");
          end
        end
        if (dn) chk("no_done_after_action", dn, 0);
        if (cyc >= act_at + 10) begin
          chk("idle_after_action", bz, 0);
          fin = 1;
        end
      end else if (dn) begin
        got = 1;
        fin = 1;
      end
      if (!fin) begin
        start = 1'b0; start4 = 1'b0; abort = 1'b0; reset = 1'b0;
        seek_done = 1'b0; dump = 1'b0; accumulator = '0;
        if (poke && cyc == 12) begin
          prn_in = ~prn0;
          if (sel == 0) start = 1'b1; else start4 = 1'b1;
        end
        if (se) begin
          if (seek_cnt == 0) begin
            nsought++;
            sought.push_back(st);
            if (first_seek < 0) first_seek = cyc;
          end
          seek_cnt++;
          cur_sh = st;
          if (seek_resp && seek_cnt == 5) seek_done = 1'b1;
        end else begin
          seek_cnt = 0;
        end
        if (seek_done && big_settle) begin
          dump = 1'b1;
          accumulator = BIG;
        end else if (cyc % 3 == 0) begin
          dump = 1'b1;
          last_dump = cyc;
          if (settle_flag) begin
            accumulator = big_settle ? BIG : acc_val(mode, cur_sh, ndump);
            settle_flag = 0;
            integ_dumps = 0;
          end else begin
            accumulator = acc_val(mode, cur_sh, ndump);
            integ_dumps++;
          end
          ndump++;
        end
        if (seek_done) settle_flag = 1;
        if (act_at < 0 && action == 1 && nsought == 2 && integ_dumps == 1 && !se) begin
          abort = 1'b1;
          start = 1'b1;
          act_at = cyc;
        end else if (act_at < 0 && action == 2 && nsought == 3 && se && seek_cnt == 2) begin
          reset = 1'b1;
          act_at = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; start4 = 1'b0; abort = 1'b0; reset = 1'b0;
    seek_done = 1'b0; dump = 1'b0; accumulator = '0;
    if (action != 0) begin
      if (!fin) chk("action_cycle_budget", 0, 1);
    end else if (!got) begin
      chk("done_within_budget", 0, 1);
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_has_entry", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("found", sel ? found_b : found_a, e.found);
      chk("timeout", sel ? timeout_b : timeout_a, e.tmo);
      chk("best_shift", sel ? best_shift_b : best_shift_a, e.shift);
      chk("best_mag", sel ? best_mag_b : best_mag_a, e.mag);
      chk("prn_held", sel ? prn_b : prn_a, e.prn);
      chk("candidates", nsought, e.ncand);
      for (int i = 0; i < sought.size(); i++) chk("sought_shift", sought[i], i * 8);
      if (e.tmo) begin
        chk("timeout_latency", cyc - first_seek, 100);
        chk("timeout_seek_en_low", se, 0);
      end else begin
        chk("final_dump_to_done", cyc - last_dump, 2);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0;
    seek_done = 1'b0; dump = 1'b0; prn_in = '0; threshold = '0; accumulator = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero_a("reset");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_best_mag", best_mag_b, 0);

    // Full sweep, no signal: four candidates, equal sums, earliest shift wins.
    drive_start(0, 5'h05, 21'd1000, 1, mk_exp(1'b0, 1'b0, 15'd0, 21'd20, 4, 5'h05));
    run_sweep(0, 0, 1, 0, 0, 0);

    // Detection at shift 16; a start issued mid-sweep must be ignored.
    drive_start(0, 5'h13, 21'd500, 1, mk_exp(1'b1, 1'b0, 15'd16, 21'd600, 3, 5'h13));
    run_sweep(0, 1, 1, 0, 1, 0);

    // Tie between shifts 0 and 8, with large dumps on seek_done and at settle.
    drive_start(0, 5'h1A, 21'd1000, 1, mk_exp(1'b0, 1'b0, 15'd0, 21'd14, 4, 5'h1A));
    run_sweep(0, 2, 1, 1, 0, 0);

    // Most negative accumulator, four dumps: 4 * (2^18 - 1) without wrap.
    drive_start(1, 5'h02, 21'h0FFFFC, 1, mk_exp(1'b1, 1'b0, 15'd0, 21'h0FFFFC, 1, 5'h02));
    run_sweep(1, 3, 1, 0, 0, 0);

    // Seek never completes.
    drive_start(0, 5'h07, 21'd1000, 1, mk_exp(1'b0, 1'b1, 15'd0, 21'd0, 1, 5'h07));
    run_sweep(0, 0, 0, 0, 0, 0);

    // Abort together with start while integrating shift 8.
    drive_start(0, 5'h09, 21'd1000, 0, mk_exp(1'b0, 1'b0, 15'd0, 21'd0, 0, 5'h00));
    run_sweep(0, 0, 1, 0, 0, 1);

    // Reset while seeking shift 16.
    drive_start(0, 5'h0B, 21'd1000, 0, mk_exp(1'b0, 1'b0, 15'd0, 21'd0, 0, 5'h00));
    run_sweep(0, 0, 1, 0, 0, 2);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_sweep_ctrl.md
# acq_sweep_ctrl

Sequences one tracking subchannel through a code-phase search for a selected PRN. For each candidate code shift it commands a seek and discards the first, partial integration. It then sums the magnitudes of DWELL integration dumps and compares the sum against a threshold. It sits between the NIOS control ports (start, PRN, threshold) and the subchannel's seek/accumulator interface, running in the 200 MHz subchannel domain.

## Interface
Parameters:
- SHIFT_WIDTH, 15: width of code-shift values.
- ACC_WIDTH, 19: width of the subchannel accumulator (two's complement).
- SHIFT_MAX, 16799: last legal code shift; the sweep ends after it.
- SHIFT_STEP, 8: code-shift increment per candidate.
- DWELL, 2: integration dumps summed per candidate; legal range 1..4.
- SEEK_TIMEOUT, 65535: cycles allowed for seek_done before the sweep aborts.

Ports (all signals on `clk`; reset is synchronous and active-high):
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to begin a sweep.
- abort, in, 1: terminate the sweep immediately.
- prn_in, in, 5: PRN to search; latched on start.
- threshold, in, ACC_WIDTH+2: detection threshold; latched on start.
- seek_done, in, 1: subchannel has reached seek_target (pulse).
- dump, in, 1: integration period ended; accumulator valid this cycle (pulse).
- accumulator, in, ACC_WIDTH: integrated correlation value.
- prn, out, 5: latched PRN driven to the subchannel.
- seek_en, out, 1: seek request to the subchannel.
- seek_target, out, SHIFT_WIDTH: code shift being sought.
- busy, out, 1: high from the cycle after start is accepted until DONE or IDLE.
- done, out, 1: one-cycle pulse on sweep completion.
- found, out, 1: threshold was met; held until the next accepted start.
- timeout, out, 1: seek timed out; held until the next accepted start.
- best_shift, out, SHIFT_WIDTH: shift with the largest sum.
- best_mag, out, ACC_WIDTH+2: that largest sum.

## Operation
States are IDLE, SEEK, SETTLE, INTEG, EVAL and DONE.
- **IDLE/DONE:**
  - start latches prn_in and threshold, sets cur_shift=0, clears best_*/found/timeout, and moves to SEEK.
  - start is ignored in all other states.
- **SEEK:**
  - seek_en=1 and seek_target=cur_shift.
  - On seek_done, move to SETTLE and clear the timeout counter.
  - If the counter reaches SEEK_TIMEOUT, set timeout=1 and move to DONE.
  - dump is ignored in SEEK.
- **SETTLE:**
  - seek_en=0.
  - The first dump is discarded, then the block moves to INTEG with sum=0 and dump count=0.
- **INTEG:**
  - On each dump, sum += mag(accumulator) and the count increments.
  - When count reaches DWELL, move to EVAL.
- **Magnitude rule:**
  - mag = |acc|; −2^(ACC_WIDTH−1) saturates to 2^(ACC_WIDTH−1)−1.
  - sum is ACC_WIDTH+2 bits and cannot overflow for DWELL≤4.
- **EVAL (one cycle):**
  - If sum > best_mag (strictly greater), update best_mag and best_shift, so the earliest shift wins ties.
  - If sum ≥ threshold, set found=1 and go to DONE; best_* reflects this shift.
  - Otherwise, if cur_shift+SHIFT_STEP > SHIFT_MAX, go to DONE with found=0.
  - Otherwise set cur_shift += SHIFT_STEP and go to SEEK. Compute the addition at SHIFT_WIDTH+1 bits so it cannot wrap.
- **DONE:** done pulses on entry; the state holds and accepts a new start.
- **abort:** from any state, go to IDLE next cycle with seek_en=0 and no done pulse. best_* and found hold their values.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: prn, seek_target, best_shift, best_mag, busy, done, found, timeout and seek_en.
- Latencies:
  - start → seek_en=1 and busy=1 next cycle.
  - seek_done → seek_en=0 next cycle.
  - Final dump → EVAL next cycle → DONE (done=1) the cycle after.
- Simultaneous events:
  - abort with start: abort wins and start is dropped.
  - reset overrides everything.
  - seek_done with dump in SEEK: the dump is not counted as the settle dump.
  - dump arriving in the same cycle as entry to SETTLE is not observed; only dumps sampled while in SETTLE count.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package acq_pkg holds:
  - the state enum;
  - the default width constants SHIFT_WIDTH, ACC_WIDTH and SUM_WIDTH = ACC_WIDTH+2;
  - the 5-bit PRN width.
- Sub-module acq_mag is a combinational abs-with-saturation of the accumulator (ACC_WIDTH in, ACC_WIDTH−1 bits out, zero-extended into the sum).
- The FSM, counters and best tracker live in acq_sweep_ctrl.

## Test plan
- **Full sweep, no signal:** SHIFT_MAX=31, STEP=8, DWELL=2, threshold=1000, accumulator=±10, seek_done after 5 cycles.
  - Required: 4 candidates (0, 8, 16, 24), then done.
  - found=0, best_shift=0, best_mag=20.
- **Detection:** accumulator=−300 only while seek_target=16, threshold=500.
  - Required: found=1, best_shift=16, best_mag=600.
  - done one cycle after EVAL; shift 24 is never sought.
- **Saturation:** accumulator=0x40000 (−2^18), DWELL=4.
  - Required: sum = 4×(2^18−1) = 0xFFFFC, with no wrap.
- **Seek timeout:** SEEK_TIMEOUT=100 and seek_done never asserted.
  - Required: timeout=1 and a done pulse 100 cycles after seek_en rises.
  - seek_en=0 afterwards.
- **Abort and reset mid-INTEG:** abort asserted with start in the same cycle.
  - Required: IDLE next cycle, no done, start ignored.
  - reset mid-sweep → all outputs 0 next cycle.
- **Tie and settle discard:** equal sums at shifts 0 and 8 → best_shift=0.
  - A large first dump after seek_done is excluded from best_mag.
